// File: rtl/gm64_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gm64_mem_pkg
//  Description : Shared encodings for the gm64 PSRAM access path: arbiter
//                state machine, access owner and memCtrl transfer size.
//  Revision    : 1.0  initial release
// ============================================================================
package gm64_mem_pkg;

    // Arbiter sequencing states
    localparam int                 STATE_W   = 3;
    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ISSUE     = 3'd1;
    localparam logic [STATE_W-1:0] WAIT_BUSY = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_DONE = 3'd3;
    localparam logic [STATE_W-1:0] RESP      = 3'd4;

    // Owner of the access currently in flight
    localparam int                 OWNER_W   = 2;
    localparam logic [OWNER_W-1:0] OWN_NONE  = 2'd0;
    localparam logic [OWNER_W-1:0] OWN_CPU   = 2'd1;
    localparam logic [OWNER_W-1:0] OWN_VIC   = 2'd2;

    // Every access moves exactly one byte through memCtrl
    localparam logic [3:0]         MEM_SINGLE_BYTE = 4'd1;

endpackage
`default_nettype wire

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psram_arbiter
//  Description : Shares memCtrl between the 6502 CPU and the VIC6569 fetch
//                port. VIC has priority, a run counter lets a waiting CPU in
//                after VIC_MAX_RUN VIC grants. One byte access at a time:
//                CE pulse, wait for busy to rise and fall, acknowledge owner.
//  Revision    : 1.0  initial release
// ============================================================================
module psram_arbiter
    import gm64_mem_pkg::*;
#(
    parameter logic [6:0] CPU_BANK    = 7'd0,
    parameter logic [6:0] VIC_BANK    = 7'd0,
    parameter int         VIC_MAX_RUN = 4,
    parameter int         TIMEOUT     = 64
) (
    input  logic        clkRAM,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vic_req,
    input  logic [15:0] vic_addr,
    output logic        vic_ack,
    output logic [7:0]  vic_rdata,
    output logic        mem_ce,
    output logic        mem_write,
    output logic [6:0]  mem_bank,
    output logic [15:0] mem_addr,
    output logic [3:0]  mem_nbytes,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_busy,
    output logic        err_timeout
);

    localparam int               RUN_W      = $clog2(VIC_MAX_RUN + 1);
    localparam int               TMO_W      = $clog2(TIMEOUT);
    localparam logic [RUN_W-1:0] c_run_max  = RUN_W'(VIC_MAX_RUN);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [OWNER_W-1:0] r_owner;
    logic [RUN_W-1:0]   r_run;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;
    logic               w_any_req;
    logic               w_pick_cpu;

    // VIC wins unless the CPU is waiting and the VIC has used up its run
    function automatic logic pick_cpu(input logic         cpu,
                                      input logic         vic,
                                      input logic [RUN_W-1:0] run);
        return cpu && (!vic || (run == c_run_max));
    endfunction

    assign w_any_req  = cpu_req | vic_req;
    assign w_pick_cpu = pick_cpu(cpu_req, vic_req, r_run);
    assign mem_nbytes = MEM_SINGLE_BYTE;

    // State register
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: one access sequenced from request to acknowledge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_any_req) w_next_state = ISSUE;
            ISSUE:     w_next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (mem_busy)                 w_next_state = WAIT_DONE;
                else if (r_tmo == c_tmo_last) w_next_state = RESP;
            end
            WAIT_DONE: if (!mem_busy) w_next_state = RESP;
            RESP:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state: CE pulse, owner ack, timeout flag
    always_comb begin
        mem_ce      = (r_state == ISSUE);
        cpu_ack     = (r_state == RESP) && (r_owner == OWN_CPU);
        vic_ack     = (r_state == RESP) && (r_owner == OWN_VIC);
        err_timeout = (r_state == RESP) && r_err;
    end

    // Latch the winner's request; held stable until the next grant
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            r_owner   <= OWN_NONE;
            mem_addr  <= 16'h0000;
            mem_bank  <= 7'd0;
            mem_write <= 1'b0;
            mem_wdata <= 8'h00;
        end else if ((r_state == IDLE) && w_any_req) begin
            if (w_pick_cpu) begin
                r_owner   <= OWN_CPU;
                mem_addr  <= cpu_addr;
                mem_bank  <= CPU_BANK;
                mem_write <= cpu_we;
                mem_wdata <= cpu_wdata;
            end else begin
                r_owner   <= OWN_VIC;
                mem_addr  <= vic_addr;
                mem_bank  <= VIC_BANK;
                mem_write <= 1'b0;
                mem_wdata <= 8'h00;
            end
        end
    end

    // Starvation guard: count VIC grants taken while the CPU is waiting
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            r_run <= '0;
        end else if (!cpu_req) begin
            r_run <= '0;
        end else if ((r_state == IDLE) && w_any_req) begin
            if (w_pick_cpu)              r_run <= '0;
            else if (r_run != c_run_max) r_run <= r_run + 1'b1;
        end
    end

    // Busy-rise watchdog; the error flag survives until the next CE
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if ((r_state == WAIT_BUSY) && !mem_busy) begin
            if (r_tmo == c_tmo_last) r_err <= 1'b1;
            else                     r_tmo <= r_tmo + 1'b1;
        end
    end

    // Capture read data as busy falls; a timed-out access never gets here
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            cpu_rdata <= 8'h00;
            vic_rdata <= 8'h00;
        end else if ((r_state == WAIT_DONE) && !mem_busy && !mem_write) begin
            if (r_owner == OWN_CPU)      cpu_rdata <= mem_rdata;
            else if (r_owner == OWN_VIC) vic_rdata <= mem_rdata;
        end
    end

endmodule
`default_nettype wire
